// File: rtl/pipeline_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//
// Shared definitions for the pipeline stall controller of the 20-bit
// pipelined processor:
//   - opcode constants the controller decodes (OP_LD, OP_ST, OP_BRZ)
//   - the controller FSM state enum
//   - default parameter values used by the interface and the modules
//   - a packed bundle of all per-stage control bits, with named constant
//     patterns for each hazard response
// ---------------------------------------------------------------------------
package pipeline_pkg;

    // Default parameter values.
    localparam int OPCODE_W_DEF    = 4;
    localparam int REG_ADDR_W_DEF  = 3;
    localparam int MEM_TIMEOUT_DEF = 64;
    localparam int STALL_CNT_W_DEF = 16;

    // Opcodes recognised by the controller.
    localparam logic [3:0] OP_LD  = 4'b0001;
    localparam logic [3:0] OP_ST  = 4'b0010;
    localparam logic [3:0] OP_BRZ = 4'b1000;

    // Controller FSM states.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // All pipeline-register controls in one packed word, so that each hazard
    // response below reads as a single pattern.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    //                                    enables  flushes
    //                                    PIIEM    IIM
    // Free-running pipe: everything advances, nothing cleared.
    localparam ctrl_t CTRL_RUN      = 8'b11111_000;
    // Held in reset: nothing loads, every clearable register is bubbled.
    localparam ctrl_t CTRL_RESET    = 8'b00000_111;
    // Memory not ready: whole pipe frozen, MEM/WB receives a bubble.
    localparam ctrl_t CTRL_FREEZE   = 8'b00000_001;
    // Taken branch: PC loads the target, the two younger instructions die.
    localparam ctrl_t CTRL_BRANCH   = 8'b11111_110;
    // Load-use: PC and IF/ID hold, a bubble enters ID/EX, older stages move.
    localparam ctrl_t CTRL_LOAD_USE = 8'b00111_010;
    // Memory timeout: pipe resumes but the failed access never writes back.
    localparam ctrl_t CTRL_TIMEOUT  = 8'b11111_001;

    // True when the MEM-stage opcode performs a data-memory access.
    function automatic logic is_mem_access(input logic [3:0] opcode);
        return (opcode == OP_LD) || (opcode == OP_ST);
    endfunction

endpackage : pipeline_pkg

// File: rtl/pipeline_stall_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_if
//
// Bundles every signal exchanged between the stall controller and the
// datapath.
//   master : the stall controller (reads stage status, drives controls)
//   slave  : the datapath (drives stage status, obeys controls)
//
// Status (datapath -> controller):
//   id_opcode, id_rs, id_rt, id_rs_used, id_rt_used  instruction in ID
//   ex_opcode, ex_rd, branch_taken                    instruction in EX
//   mem_opcode, mem_ready                             instruction in MEM
// Controls (controller -> datapath):
//   pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en   register load enables
//   if_id_flush, id_ex_flush, mem_wb_flush            synchronous bubble
//   mem_error                                         sticky memory timeout
//   stall_cycles                                      cycles with pc_en=0
// ---------------------------------------------------------------------------
interface pipeline_stall_controller_if #(
    parameter int OPCODE_W    = pipeline_pkg::OPCODE_W_DEF,
    parameter int REG_ADDR_W  = pipeline_pkg::REG_ADDR_W_DEF,
    parameter int STALL_CNT_W = pipeline_pkg::STALL_CNT_W_DEF
) ();

    // ID stage
    logic [OPCODE_W-1:0]    id_opcode;
    logic [REG_ADDR_W-1:0]  id_rs;
    logic [REG_ADDR_W-1:0]  id_rt;
    logic                   id_rs_used;
    logic                   id_rt_used;

    // EX stage
    logic [OPCODE_W-1:0]    ex_opcode;
    logic [REG_ADDR_W-1:0]  ex_rd;
    logic                   branch_taken;

    // MEM stage
    logic [OPCODE_W-1:0]    mem_opcode;
    logic                   mem_ready;

    // Pipeline-register controls
    logic                   pc_en;
    logic                   if_id_en;
    logic                   id_ex_en;
    logic                   ex_mem_en;
    logic                   mem_wb_en;
    logic                   if_id_flush;
    logic                   id_ex_flush;
    logic                   mem_wb_flush;

    // Status
    logic                   mem_error;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        input  id_opcode, id_rs, id_rt, id_rs_used, id_rt_used,
        input  ex_opcode, ex_rd, branch_taken,
        input  mem_opcode, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output mem_error, stall_cycles
    );

    modport slave (
        output id_opcode, id_rs, id_rt, id_rs_used, id_rt_used,
        output ex_opcode, ex_rd, branch_taken,
        output mem_opcode, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  mem_error, stall_cycles
    );

endinterface : pipeline_stall_controller_if

// File: rtl/pipeline_stall_controller_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_detect
//
// Purely combinational load-use comparator. A load sitting in EX produces its
// data too late for the instruction in ID if that instruction reads the
// load's destination register. Register 0 gets no special treatment: a match
// on it still counts as a hazard.
//
// Ports:
//   ex_opcode   in   opcode of the instruction in EX
//   ex_rd       in   destination register of the instruction in EX
//   id_rs/rt    in   source registers of the instruction in ID
//   id_rs_used  in   id_rs is really read by the ID instruction
//   id_rt_used  in   id_rt is really read by the ID instruction
//   load_use    out  hazard present this cycle
// ---------------------------------------------------------------------------
module pipeline_hazard_detect
    import pipeline_pkg::*;
#(
    parameter int OPCODE_W   = OPCODE_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [OPCODE_W-1:0]   ex_opcode,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    output logic                  load_use
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    assign ex_is_load = (ex_opcode == OPCODE_W'(OP_LD));
    assign rs_match   = id_rs_used && (id_rs == ex_rd);
    assign rt_match   = id_rt_used && (id_rt == ex_rd);
    assign load_use   = ex_is_load && (rs_match || rt_match);

endmodule : pipeline_hazard_detect

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Generates the load enables and synchronous clears of the PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB registers. Three hazards are handled:
//   - load-use      : one bubble into ID/EX while PC and IF/ID hold
//   - taken branch  : IF/ID and ID/EX flushed in the resolving cycle
//   - memory wait   : whole pipe frozen until mem_ready, with a timeout that
//                     sets a sticky mem_error and drops the failed writeback
//
// The controls are a Mealy function of the registered FSM state and the
// current stage status; FSM state, timeout counter, mem_error and the stall
// statistics counter are registered.
//
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  synchronous, active-high; forces every register to bubble
//   bus    master side of pipeline_stall_controller_if (stage status in,
//          pipeline-register controls and status out)
// ---------------------------------------------------------------------------
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int OPCODE_W    = OPCODE_W_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    pipeline_stall_controller_if.master bus
);

    // Wide enough to hold MEM_TIMEOUT-1, the last count before giving up.
    localparam int                TO_W         = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_t                 state;
    logic [TO_W-1:0]        to_cnt;
    logic                   mem_error_q;
    logic [STALL_CNT_W-1:0] stall_q;

    ctrl_t                  ctrl;
    logic                   mem_access;
    logic                   load_use;
    logic                   start_wait;
    logic                   wait_done;
    logic                   wait_timeout;

    // -----------------------------------------------------------------------
    // Load-use comparator
    // -----------------------------------------------------------------------
    pipeline_hazard_detect #(
        .OPCODE_W   (OPCODE_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .ex_opcode  (bus.ex_opcode),
        .ex_rd      (bus.ex_rd),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_rs_used (bus.id_rs_used),
        .id_rt_used (bus.id_rt_used),
        .load_use   (load_use)
    );

    assign mem_access = (bus.mem_opcode == OPCODE_W'(OP_LD)) ||
                        (bus.mem_opcode == OPCODE_W'(OP_ST));

    // -----------------------------------------------------------------------
    // Output decode and FSM transition events
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the if/case tree leaves one unassigned and infers a latch.
        ctrl         = CTRL_RUN;
        start_wait   = 1'b0;
        wait_done    = 1'b0;
        wait_timeout = 1'b0;

        if (reset) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (state)
                RUN: begin
                    // A stalled memory access outranks everything: EX is
                    // frozen, so a branch or load-use there waits with it.
                    if (mem_access && !bus.mem_ready) begin
                        ctrl       = CTRL_FREEZE;
                        start_wait = 1'b1;
                    end else if (bus.branch_taken) begin
                        // The ID instruction is killed, so any load-use
                        // hazard it has is irrelevant.
                        ctrl = CTRL_BRANCH;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end

                MEM_WAIT: begin
                    // Branch and load-use are ignored for the whole wait,
                    // including the completing cycle; they are re-evaluated
                    // in the first RUN cycle afterwards.
                    if (bus.mem_ready) begin
                        wait_done = 1'b1;
                    end else if (to_cnt == TIMEOUT_LAST) begin
                        ctrl         = CTRL_TIMEOUT;
                        wait_timeout = 1'b1;
                    end else begin
                        ctrl = CTRL_FREEZE;
                    end
                end

                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM, timeout counter, sticky error and stall statistics
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state       <= RUN;
            to_cnt      <= '0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            if (start_wait) begin
                // The first not-ready cycle was spent in RUN, so the count
                // already stands at one when the wait state is entered.
                state  <= MEM_WAIT;
                to_cnt <= TO_W'(1);
            end else if (wait_done || wait_timeout) begin
                state  <= RUN;
                to_cnt <= '0;
            end else if (state == MEM_WAIT) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (wait_timeout) begin
                mem_error_q <= 1'b1;
            end

            if (!ctrl.pc_en && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.mem_error    = mem_error_q;
    assign bus.stall_cycles = stall_q;

endmodule : pipeline_stall_controller

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Drives directed hazard scenarios followed by random stage traffic. For
// every cycle the driver asks a behavioural model what the controller should
// output and queues that expectation; a monitor on the falling edge pops the
// queue and compares against the live DUT outputs.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;
    import pipeline_pkg::*;

    localparam int OPW = 4;
    localparam int RAW = 3;
    localparam int TO  = 64;
    localparam int SCW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    pipeline_stall_controller_if #(
        .OPCODE_W    (OPW),
        .REG_ADDR_W  (RAW),
        .STALL_CNT_W (SCW)
    ) bus_if ();

    pipeline_stall_controller #(
        .OPCODE_W    (OPW),
        .REG_ADDR_W  (RAW),
        .MEM_TIMEOUT (TO),
        .STALL_CNT_W (SCW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    // One cycle of datapath status.
    typedef struct {
        logic           rst;
        logic [OPW-1:0] id_op;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic           rs_used;
        logic           rt_used;
        logic [OPW-1:0] ex_op;
        logic [RAW-1:0] ex_rd;
        logic           br;
        logic [OPW-1:0] mem_op;
        logic           rdy;
    } stim_t;

    // Expected outputs for one cycle.
    // en = {pc, if_id, id_ex, ex_mem, mem_wb}, fl = {if_id, id_ex, mem_wb}
    typedef struct {
        logic [4:0]     en;
        logic [2:0]     fl;
        logic           err;
        logic [SCW-1:0] stalls;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model state ----------------
    // waited  : not-ready cycles already spent on the access in MEM (0 = none)
    // m_err   : a timeout has happened since reset
    // m_stalls: cycles so far in which the PC did not advance
    int waited   = 0;
    bit m_err    = 1'b0;
    int m_stalls = 0;

    task automatic model_step(input stim_t s, output exp_t e);
        bit access;
        bit hazard;
        e.err    = m_err;
        e.stalls = SCW'(m_stalls);
        if (s.rst) begin
            e.en = 5'b00000;
            e.fl = 3'b111;
            waited   = 0;
            m_err    = 1'b0;
            m_stalls = 0;
            return;
        end
        access = (s.mem_op == OP_LD) || (s.mem_op == OP_ST);
        hazard = (s.ex_op == OP_LD) &&
                 ((s.rs_used && s.rs == s.ex_rd) || (s.rt_used && s.rt == s.ex_rd));
        if (waited > 0) begin
            // Pipe is frozen on an outstanding access; nothing else matters.
            if (s.rdy) begin
                e.en = 5'b11111; e.fl = 3'b000; waited = 0;
            end else if (waited + 1 == TO) begin
                e.en = 5'b11111; e.fl = 3'b001; waited = 0; m_err = 1'b1;
            end else begin
                e.en = 5'b00000; e.fl = 3'b001; waited = waited + 1;
            end
        end else if (access && !s.rdy) begin
            e.en = 5'b00000; e.fl = 3'b001; waited = 1;
        end else if (s.br) begin
            e.en = 5'b11111; e.fl = 3'b110;
        end else if (hazard) begin
            e.en = 5'b00111; e.fl = 3'b010;
        end else begin
            e.en = 5'b11111; e.fl = 3'b000;
        end
        if (!e.en[4] && m_stalls < (1 << SCW) - 1) m_stalls = m_stalls + 1;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b0; s.id_op = 4'b0100; s.rs = '0; s.rt = '0;
        s.rs_used = 1'b0; s.rt_used = 1'b0; s.ex_op = 4'b0100; s.ex_rd = '0;
        s.br = 1'b0; s.mem_op = 4'b0100; s.rdy = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst     = 1'b0;
        s.id_op   = OPW'($urandom_range(0, 15));
        s.rs      = RAW'($urandom_range(0, 7));
        s.rt      = RAW'($urandom_range(0, 7));
        s.rs_used = 1'($urandom_range(0, 1));
        s.rt_used = 1'($urandom_range(0, 1));
        s.ex_op   = ($urandom_range(0, 1) == 0) ? OP_LD : OPW'($urandom_range(0, 15));
        s.ex_rd   = RAW'($urandom_range(0, 7));
        s.br      = ($urandom_range(0, 4) == 0);
        case ($urandom_range(0, 3))
            0:       s.mem_op = OP_LD;
            1:       s.mem_op = OP_ST;
            default: s.mem_op = OPW'($urandom_range(0, 15));
        endcase
        s.rdy     = ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset               = s.rst;
        bus_if.id_opcode    = s.id_op;
        bus_if.id_rs        = s.rs;
        bus_if.id_rt        = s.rt;
        bus_if.id_rs_used   = s.rs_used;
        bus_if.id_rt_used   = s.rt_used;
        bus_if.ex_opcode    = s.ex_op;
        bus_if.ex_rd        = s.ex_rd;
        bus_if.branch_taken = s.br;
        bus_if.mem_opcode   = s.mem_op;
        bus_if.mem_ready    = s.rdy;
    endtask

    // Drive one cycle just after the rising edge and queue its expectation.
    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clock);
        #1;
        apply(s);
        model_step(s, e);
        exp_q.push_back(e);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc_en",        32'(bus_if.pc_en),        32'(e.en[4]));
            check("if_id_en",     32'(bus_if.if_id_en),     32'(e.en[3]));
            check("id_ex_en",     32'(bus_if.id_ex_en),     32'(e.en[2]));
            check("ex_mem_en",    32'(bus_if.ex_mem_en),    32'(e.en[1]));
            check("mem_wb_en",    32'(bus_if.mem_wb_en),    32'(e.en[0]));
            check("if_id_flush",  32'(bus_if.if_id_flush),  32'(e.fl[2]));
            check("id_ex_flush",  32'(bus_if.id_ex_flush),  32'(e.fl[1]));
            check("mem_wb_flush", 32'(bus_if.mem_wb_flush), 32'(e.fl[0]));
            check("mem_error",    32'(bus_if.mem_error),    32'(e.err));
            check("stall_cycles", 32'(bus_if.stall_cycles), 32'(e.stalls));
        end
    end

    // ---------------- scenario sequence ----------------
    initial begin
        stim_t s;
        apply(idle_stim());
        reset = 1'b1;
        // One edge under reset puts DUT and model in the same known state.
        @(posedge clock);

        // Reset held for three checked cycles, then normal RUN.
        s = idle_stim(); s.rst = 1'b1;
        repeat (3) drive(s);
        drive(idle_stim());

        // Load-use: one bubble, then the load has moved to MEM.
        s = idle_stim(); s.ex_op = OP_LD; s.ex_rd = 3'd3; s.rs = 3'd3; s.rs_used = 1'b1;
        drive(s);
        s = idle_stim(); s.mem_op = OP_LD; s.rdy = 1'b1;
        drive(s);
        // Load-use on rt via register 0.
        s = idle_stim(); s.ex_op = OP_LD; s.ex_rd = 3'd0; s.rt = 3'd0; s.rt_used = 1'b1;
        drive(s);
        drive(idle_stim());
        // Matching register but source not used: no stall.
        s = idle_stim(); s.ex_op = OP_LD; s.ex_rd = 3'd5; s.rs = 3'd5; s.rs_used = 1'b0;
        drive(s);

        // Branch in the same cycle as a load-use hazard: branch wins.
        s = idle_stim(); s.ex_op = OP_LD; s.ex_rd = 3'd3; s.rs = 3'd3; s.rs_used = 1'b1;
        s.br = 1'b1;
        drive(s);
        drive(idle_stim());

        // Memory wait: five not-ready cycles (with a branch and a load-use
        // showing up meanwhile), then ready; the held branch acts afterwards.
        s = idle_stim(); s.mem_op = OP_LD; s.rdy = 1'b0;
        repeat (2) drive(s);
        s.br = 1'b1;
        drive(s);
        s.br = 1'b0; s.ex_op = OP_LD; s.ex_rd = 3'd2; s.rt = 3'd2; s.rt_used = 1'b1;
        repeat (2) drive(s);
        s = idle_stim(); s.mem_op = OP_LD; s.rdy = 1'b1; s.br = 1'b1;
        drive(s);
        s = idle_stim(); s.br = 1'b1;
        drive(s);
        // Memory ready in the first cycle of access: no stall.
        s = idle_stim(); s.mem_op = OP_ST; s.rdy = 1'b1;
        drive(s);
        drive(idle_stim());

        // Store that never completes: timeout after 64 not-ready cycles.
        s = idle_stim(); s.mem_op = OP_ST; s.rdy = 1'b0;
        repeat (TO) drive(s);
        repeat (4) drive(idle_stim());

        // Random traffic.
        for (int i = 0; i < 400; i++) drive(rand_stim());
        drive(idle_stim());

        // Reset in the third cycle of a memory wait.
        s = idle_stim(); s.mem_op = OP_LD; s.rdy = 1'b0;
        repeat (2) drive(s);
        s.rst = 1'b1;
        drive(s);
        repeat (2) drive(idle_stim());

        // More random traffic after the reset.
        for (int i = 0; i < 200; i++) drive(rand_stim());

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
        @(posedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_stall_controller
